// File: rtl/led_pattern_gen_if.sv
// ============================================================================
// Module      : led_pattern_gen_if
// Description : Control/drive bundle for the LED pattern engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_pattern_gen_if #(
    parameter int NUM_LEDS = 5
);
    logic                en;
    logic [1:0]          mode;
    logic [NUM_LEDS-1:0] pattern;
    logic [NUM_LEDS-1:0] led;
    logic                step;

    modport master (
        output en,
        output mode,
        output pattern,
        input  led,
        input  step
    );

    modport slave (
        input  en,
        input  mode,
        input  pattern,
        output led,
        output step
    );
endinterface

`default_nettype wire

// File: rtl/led_pattern_gen.sv
// ============================================================================
// Module      : led_pattern_gen
// Description : N-channel LED engine with static, blink, chase and bounce modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_gen #(
    parameter int NUM_LEDS = 5,
    parameter int STEP_DIV = 3_000_000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    led_pattern_gen_if.slave  bus
);
    localparam int                 c_CNT_W   = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STEP_DIV - 1);
    localparam logic [NUM_LEDS-1:0] c_LED0   = {{(NUM_LEDS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    mode_t               r_mode_q;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [NUM_LEDS-1:0] r_led;
    logic                r_dir;
    logic                r_phase;
    logic                r_step;

    logic                w_mode_chg;
    logic                w_tick;
    logic [NUM_LEDS-1:0] w_entry_led;

    assign w_mode_chg = (mode_t'(bus.mode) != r_mode_q);
    assign w_tick     = bus.en && (r_cnt == c_CNT_MAX);

    always_comb begin
        w_entry_led = '0;
        case (mode_t'(bus.mode))
            MODE_STATIC: w_entry_led = bus.pattern;
            MODE_BLINK:  w_entry_led = '0;
            MODE_CHASE:  w_entry_led = c_LED0;
            MODE_BOUNCE: w_entry_led = c_LED0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_q <= MODE_STATIC;
            r_cnt    <= '0;
            r_led    <= '0;
            r_dir    <= 1'b0;
            r_phase  <= 1'b0;
            r_step   <= 1'b0;
        end else if (w_mode_chg) begin
            // Mode entry restarts the animation and suppresses any coincident tick
            r_mode_q <= mode_t'(bus.mode);
            r_cnt    <= '0;
            r_led    <= w_entry_led;
            r_dir    <= 1'b0;
            r_phase  <= 1'b0;
            r_step   <= 1'b0;
        end else begin
            if (bus.en) begin
                r_cnt <= (r_cnt == c_CNT_MAX) ? '0 : r_cnt + 1'b1;
            end
            r_step <= w_tick;

            case (r_mode_q)
                MODE_STATIC: r_led <= bus.pattern;
                MODE_BLINK: begin
                    if (w_tick) begin
                        r_phase <= ~r_phase;
                        r_led   <= {NUM_LEDS{~r_phase}};
                    end
                end
                MODE_CHASE: begin
                    if (w_tick) begin
                        r_led <= {r_led[NUM_LEDS-2:0], r_led[NUM_LEDS-1]};
                    end
                end
                MODE_BOUNCE: begin
                    if (w_tick) begin
                        // Endpoints reverse direction so each end is lit for one step only
                        if (!r_dir) begin
                            if (r_led[NUM_LEDS-1]) begin
                                r_led <= r_led >> 1;
                                r_dir <= 1'b1;
                            end else begin
                                r_led <= r_led << 1;
                            end
                        end else begin
                            if (r_led[0]) begin
                                r_led <= r_led << 1;
                                r_dir <= 1'b0;
                            end else begin
                                r_led <= r_led >> 1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.led  = r_led;
    assign bus.step = r_step;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
// ============================================================================
// Module      : tb_led_pattern_gen
// Description : Scoreboard bench for led_pattern_gen (NUM_LEDS=5, STEP_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_gen;
    localparam int NUM_LEDS = 5;
    localparam int STEP_DIV = 4;

    typedef struct {
        logic [NUM_LEDS-1:0] led;
        logic                step;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc_n;
    exp_t sb_q[$];

    // Reference model state
    int                  m_mode;
    int                  m_cnt;
    int                  m_pos;
    int                  m_dir;
    int                  m_phase;
    logic [NUM_LEDS-1:0] m_led;
    logic                m_step;

    led_pattern_gen_if #(.NUM_LEDS(NUM_LEDS)) bus ();

    led_pattern_gen #(
        .NUM_LEDS(NUM_LEDS),
        .STEP_DIV(STEP_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input int md,
                              input logic [NUM_LEDS-1:0] pat);
        bit tk;
        if (r) begin
            m_mode = 0; m_cnt = 0; m_pos = 0; m_dir = 0; m_phase = 0;
            m_led = '0; m_step = 1'b0;
        end else if (md != m_mode) begin
            m_mode = md; m_cnt = 0; m_pos = 0; m_dir = 0; m_phase = 0; m_step = 1'b0;
            m_led = (md == 0) ? pat : (md == 1) ? '0 : NUM_LEDS'(1);
        end else begin
            tk = e && (m_cnt == STEP_DIV - 1);
            if (e) m_cnt = (m_cnt + 1) % STEP_DIV;
            m_step = tk;
            if (m_mode == 0) begin
                m_led = pat;
            end else if (tk) begin
                if (m_mode == 1) begin
                    m_phase = 1 - m_phase;
                    m_led   = (m_phase != 0) ? '1 : '0;
                end else if (m_mode == 2) begin
                    m_pos = (m_pos + 1) % NUM_LEDS;
                    m_led = NUM_LEDS'(1) << m_pos;
                end else begin
                    m_pos = (m_dir != 0) ? m_pos - 1 : m_pos + 1;
                    if (m_pos == NUM_LEDS - 1) m_dir = 1;
                    if (m_pos == 0) m_dir = 0;
                    m_led = NUM_LEDS'(1) << m_pos;
                end
            end
        end
    endtask

    // One clock: drive inputs, push the model's prediction, compare after the edge
    task automatic cyc(input logic r, input logic e, input int md,
                       input logic [NUM_LEDS-1:0] pat);
        exp_t ex;
        exp_t got;
        rst         = r;
        bus.en      = e;
        bus.mode    = 2'(md);
        bus.pattern = pat;
        model_edge(r, e, md, pat);
        ex.led  = m_led;
        ex.step = m_step;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        cyc_n++;
        got = sb_q.pop_front();
        check("sb_led", 32'(bus.led), 32'(got.led));
        check("sb_step", 32'(bus.step), 32'(got.step));
    endtask

    function automatic int pos_of(input logic [NUM_LEDS-1:0] v);
        for (int i = 0; i < NUM_LEDS; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        logic [NUM_LEDS-1:0] chase_exp [6];
        int                  bounce_exp [10];
        int                  nsteps;
        int                  last_t;
        logic [NUM_LEDS-1:0] prev;

        n_checks = 0; n_errors = 0; cyc_n = 0;
        rst = 1'b1; bus.en = 1'b0; bus.mode = 2'd0; bus.pattern = '0;
        chase_exp  = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001, 5'b00010};
        bounce_exp = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};

        // Reset and STATIC
        cyc(1, 1, 0, 5'b10110);
        check("reset_led", 32'(bus.led), 32'h0);
        check("reset_step", 32'(bus.step), 32'h0);
        cyc(1, 1, 0, 5'b10110);
        cyc(0, 1, 0, 5'b10110);
        check("static_first", 32'(bus.led), 32'b10110);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 5'b10110);
        cyc(0, 1, 0, 5'b00001);
        check("static_follow", 32'(bus.led), 32'b00001);
        nsteps = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, 0, 5'b00001);
            if (bus.step) nsteps++;
        end
        check("static_steps", 32'(nsteps), 32'd2);

        // CHASE
        cyc(0, 1, 2, 5'b00000);
        check("chase_entry", 32'(bus.led), 32'b00001);
        nsteps = 0;
        for (int i = 0; i < 24; i++) begin
            prev = bus.led;
            cyc(0, 1, 2, 5'b00000);
            if (bus.led != prev) begin
                check("chase_step_align", 32'(bus.step), 32'd1);
                if (nsteps < 6) check("chase_seq", 32'(bus.led), 32'(chase_exp[nsteps]));
                nsteps++;
            end
        end
        check("chase_count", 32'(nsteps), 32'd6);

        // BOUNCE
        cyc(0, 1, 3, 5'b00000);
        nsteps = 0;
        check("bounce_seq", 32'(pos_of(bus.led)), 32'(bounce_exp[0]));
        for (int i = 0; i < 36; i++) begin
            cyc(0, 1, 3, 5'b00000);
            check("bounce_onehot", 32'($countones(bus.led)), 32'd1);
            if (bus.step) begin
                nsteps++;
                if (nsteps < 10) check("bounce_seq", 32'(pos_of(bus.led)), 32'(bounce_exp[nsteps]));
            end
        end
        check("bounce_count", 32'(nsteps), 32'd9);

        // BLINK with an en gap after the first toggle
        cyc(0, 1, 1, 5'b00000);
        check("blink_entry", 32'(bus.led), 32'h0);
        last_t = -1;
        for (int i = 0; i < 8 && last_t < 0; i++) begin
            cyc(0, 1, 1, 5'b00000);
            if (bus.step) last_t = cyc_n;
        end
        check("blink_on", 32'(bus.led), 32'b11111);
        cyc(0, 1, 1, 5'b00000);
        cyc(0, 1, 1, 5'b00000);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 5'b00000);
        for (int i = 0; i < 10 && !bus.step; i++) cyc(0, 1, 1, 5'b00000);
        check("blink_gap", 32'(cyc_n - last_t), 32'd7);
        check("blink_off", 32'(bus.led), 32'b00000);
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 5'b00000);

        // Mode change coinciding with a tick
        cyc(0, 1, 2, 5'b00000);
        for (int i = 0; i < 3; i++) cyc(0, 1, 2, 5'b00000);
        cyc(0, 1, 3, 5'b00000);
        check("tickchg_led", 32'(bus.led), 32'b00001);
        check("tickchg_step", 32'(bus.step), 32'd0);
        nsteps = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 3, 5'b00000);
            if (bus.step) nsteps++;
        end
        cyc(0, 1, 3, 5'b00000);
        check("tickchg_nostep", 32'(nsteps), 32'd0);
        check("tickchg_adv", 32'(bus.led), 32'b00010);

        // Reset mid-BOUNCE while descending
        for (int i = 0; i < 16; i++) cyc(0, 1, 3, 5'b00000);
        check("pre_rst_pos", 32'(bus.led), 32'b01000);
        cyc(1, 1, 3, 5'b00000);
        check("rst_led", 32'(bus.led), 32'h0);
        check("rst_step", 32'(bus.step), 32'd0);
        cyc(0, 1, 3, 5'b00000);
        check("reentry_led", 32'(bus.led), 32'b00001);
        for (int i = 0; i < 4; i++) cyc(0, 1, 3, 5'b00000);
        check("reentry_up", 32'(bus.led), 32'b00010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine for the iCEstick LED bank, generalising fixed on/off LED assignment to N channels with four run-time-selectable modes: static, blink, chase and bounce. A free-running prescaler derives a step tick from the system clock. The block sits directly in front of the board LED pins, with mode and pattern driven from switches or a control block.

## Interface
- NUM_LEDS, default 5: LED channel count; must be ≥ 2.
- STEP_DIV, default 3_000_000: clock cycles per animation step (4 Hz at 12 MHz); must be ≥ 2.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run enable; low freezes the prescaler and animation.
- mode  input  2  pattern select: 0 STATIC, 1 BLINK, 2 CHASE, 3 BOUNCE.
- pattern  input  NUM_LEDS  LED values used in STATIC mode.
- led  output  NUM_LEDS  registered LED drive; 1 means on.
- step  output  1  registered one-cycle strobe, high in the cycle after each animation advance.

## Operation
- State registers:
  - mode_q (2 b)
  - prescaler cnt (width $clog2(STEP_DIV))
  - one-hot position, held in led for CHASE and BOUNCE
  - dir (0 = up, 1 = down)
  - blink phase
- Reset values: led = 0, step = 0, cnt = 0, mode_q = 0, dir = 0, phase = 0.
- Tick: cnt counts 0..STEP_DIV−1 while en = 1, then wraps to 0. tick = en & (cnt == STEP_DIV−1). While en = 0, cnt holds its value.
- Mode entry: on any cycle where mode ≠ mode_q, the following happens at the next edge:
  - mode_q ← mode, cnt ← 0, dir ← 0, phase ← 0, step ← 0.
  - led ← entry value: STATIC gives pattern; BLINK gives all 0; CHASE gives 1 (LED0); BOUNCE gives 1.
  - No advance occurs in that cycle, even if tick is also true.
- STATIC: every edge, led ← pattern, whatever the values of en and tick. step is still pulsed on tick.
- BLINK: on tick, phase toggles and led ← {NUM_LEDS{~phase}}.
- CHASE: on tick, led rotates left by one. LED NUM_LEDS−1 wraps to LED0.
- BOUNCE: on tick, the lit LED moves one position up (dir = 0) or down (dir = 1).
  - If at NUM_LEDS−1 while going up: move to NUM_LEDS−2 and set dir = 1.
  - If at LED0 while going down: move to LED1 and set dir = 0.
  - Each endpoint is lit for exactly one step. For N = 5 the sequence is 0,1,2,3,4,3,2,1,0,1,…
- step ← tick & ~(mode ≠ mode_q); otherwise step ← 0.
- In CHASE and BOUNCE, exactly one LED is lit at all times after entry.

## Timing
- Latency from a pattern change to led, in STATIC: 1 cycle.
- Latency from a mode change to the entry value on led: 1 cycle.
- After mode entry at edge E, the first advance happens at edge E + STEP_DIV when en stays high. Later advances are every STEP_DIV cycles.
- step is high for exactly 1 cycle, aligned with the cycle in which the newly advanced led value is visible.
- Deasserting en for K cycles delays the next advance by exactly K cycles, because cnt resumes from its held value.
- Reset asserted mid-operation: at the next edge all registers take their reset values, which overrides a pending tick or mode change. After reset releases, mode_q = 0. Any mode ≠ 0 is therefore entered 1 cycle later, and with mode = 0, led ← pattern on the first edge.
- Changing mode during the tick cycle: the mode change wins, there is no advance, and the prescaler restarts.

## Test plan
All scenarios use NUM_LEDS = 5 and STEP_DIV = 4.
- Reset, then mode = 0 and pattern = 5'b10110: led = 0 during reset and 5'b10110 one cycle after release; when pattern changes to 5'b00001, led follows one cycle later; step pulses every 4 cycles.
- mode = 2 with en = 1: after entry led = 00001, then every 4 cycles 00010, 00100, 01000, 10000, 00001 (wrap); step is high for 1 cycle at each change.
- mode = 3 for 10 steps: led positions follow 0,1,2,3,4,3,2,1,0,1 with exactly one bit set throughout.
- mode = 1, with en low for 3 cycles mid-count: led alternates 00000 and 11111, and the toggle following the en gap comes 7 cycles after the previous one instead of 4.
- Switch mode from 2 to 3 in the same cycle as a tick: there is no advance and no step, led = 00001 one cycle later, and the next advance comes 4 cycles after entry.
- Assert rst for 1 cycle mid-BOUNCE while dir = 1: led = 0, step = 0 and mode_q = 0 one cycle later, then BOUNCE is re-entered with led = 00001 and dir = up.
